// File: rtl/spi_md5_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_md5_pkg                                                     |
// | Purpose  : Shared constants for the SPI/MD5 command controller: command    |
// |            opcodes, FSM state encoding, status word bit positions and the  |
// |            default SPI frame width.                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package spi_md5_pkg;

    localparam int DEF_WORD_W = 32;

    // Command opcodes, carried in frame[31:24] while the controller is idle
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WR_MSG  = 8'h01;
    localparam logic [7:0] OP_START   = 8'h02;
    localparam logic [7:0] OP_RD_STAT = 8'h03;
    localparam logic [7:0] OP_RD_DIG  = 8'h04;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DIG  = 2'd2;

    // Status word bit positions; bits [1:0] are a fixed 2'b01 marker so the
    // host can tell a real status word from an idle all-zero MISO word.
    localparam int STAT_MARK0 = 0;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_DONE  = 3;
    localparam int STAT_ERR   = 4;

    function automatic logic [31:0] status_word(input logic err,
                                                input logic done,
                                                input logic busy);
        logic [31:0] w;
        w             = 32'h0;
        w[STAT_MARK0] = 1'b1;
        w[STAT_BUSY]  = busy;
        w[STAT_DONE]  = done;
        w[STAT_ERR]   = err;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_md5_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_md5_ctrl_if                                                 |
// | Purpose  : Bundles the SPI shifter side and the MD5 core side of the       |
// |            command controller.                                             |
// |   ss, shift_complete, mosi_word : from the SPI shifter (sck domain)        |
// |   miso_word                     : to the SPI shifter                       |
// |   msg_we, msg_addr, msg_data    : message buffer write port to MD5 core    |
// |   md5_start                     : start pulse to MD5 core                  |
// |   md5_busy, md5_done, digest    : from MD5 core                            |
// |   modport master : controller view      modport slave : environment view   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface spi_md5_ctrl_if #(
    parameter int WORD_W    = 32,
    parameter int DIG_WORDS = 4
);
    logic                        ss;
    logic                        shift_complete;
    logic [WORD_W-1:0]           mosi_word;
    logic [WORD_W-1:0]           miso_word;
    logic                        msg_we;
    logic [3:0]                  msg_addr;
    logic [WORD_W-1:0]           msg_data;
    logic                        md5_start;
    logic                        md5_busy;
    logic                        md5_done;
    logic [DIG_WORDS*WORD_W-1:0] digest;

    modport master (
        input  ss, shift_complete, mosi_word, md5_busy, md5_done, digest,
        output miso_word, msg_we, msg_addr, msg_data, md5_start
    );

    modport slave (
        output ss, shift_complete, mosi_word, md5_busy, md5_done, digest,
        input  miso_word, msg_we, msg_addr, msg_data, md5_start
    );

endinterface
`default_nettype wire

// File: rtl/sync2_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync2_edge                                                      |
// | Purpose  : Two-flop synchronizer for a single asynchronous level, plus a   |
// |            third flop for rising/falling edge detection in the clk domain. |
// |   clk, rst  : system clock, synchronous active-high reset                   |
// |   i_async   : asynchronous input level                                      |
// |   o_level   : synchronized level                                           |
// |   o_rise    : one-cycle pulse on synchronized 0->1                         |
// |   o_fall    : one-cycle pulse on synchronized 1->0                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync2_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q;
    assign o_rise  = sync_q & ~prev_q;
    assign o_fall  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_md5_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_md5_ctrl                                                    |
// | Purpose  : System-clock command controller between the 32-bit SPI slave    |
// |            shifter and the MD5 core. Decodes command frames, loads the     |
// |            16-word message buffer, starts the core and stages status and   |
// |            digest words onto the shifter's MISO word.                      |
// |   clk : system clock (>= 16 x sck)   rst : synchronous active-high reset   |
// |   bus : spi_md5_ctrl_if.master (shifter + MD5 core signals)                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_md5_ctrl
    import spi_md5_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MSG_WORDS = 16,
    parameter int DIG_WORDS = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    spi_md5_ctrl_if.master bus
);

    localparam int CNT_W = 4;

    // ------------------------------------------------------------------
    // Clock-domain crossing of frame-done and slave-select
    // ------------------------------------------------------------------
    logic frame_ev;
    logic ss_rise;
    logic sc_level, sc_fall, ss_level, ss_fall;

    sync2_edge u_sync_sc (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.shift_complete),
        .o_level (sc_level),
        .o_rise  (frame_ev),
        .o_fall  (sc_fall)
    );

    sync2_edge u_sync_ss (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.ss),
        .o_level (ss_level),
        .o_rise  (ss_rise),
        .o_fall  (ss_fall)
    );

    // Only the edges that matter to the controller are consumed.
    logic unused_sync;
    assign unused_sync = ^{sc_level, sc_fall, ss_level, ss_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [WORD_W-1:0] frame_q,  frame_d;
    logic [WORD_W-1:0] miso_q,   miso_d;
    logic              we_q,     we_d;
    logic [3:0]        addr_q,   addr_d;
    logic              start_q,  start_d;
    logic              err_q,    err_d;
    logic              done_l_q, done_l_d;

    // Digest word selected by the counter; word 0 is the most significant.
    logic [WORD_W-1:0] dig_sel;
    logic [WORD_W-1:0] dig_word0;

    always_comb begin
        dig_sel = '0;
        for (int k = 0; k < DIG_WORDS; k++) begin
            if (cnt_q == k[CNT_W-1:0]) begin
                dig_sel = bus.digest[(DIG_WORDS-1-k)*WORD_W +: WORD_W];
            end
        end
    end

    assign dig_word0 = bus.digest[DIG_WORDS*WORD_W-1 -: WORD_W];

    logic [7:0] opcode;
    logic       set_err;
    logic       clr_err;
    logic       clr_done;

    // The frame is decoded straight from mosi_word in the frame_ev cycle so
    // the response reaches miso_word one clk after frame_ev.
    assign opcode = bus.mosi_word[WORD_W-1 -: 8];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        miso_d   = miso_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        start_d  = 1'b0;
        err_d    = err_q;
        done_l_d = done_l_q;
        set_err  = 1'b0;
        clr_err  = 1'b0;
        clr_done = 1'b0;

        if (frame_ev) begin
            frame_d = bus.mosi_word;
            miso_d  = '0;
            case (state_q)
                ST_IDLE: begin
                    case (opcode)
                        OP_NOP: ;
                        OP_WR_MSG: begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                        end
                        OP_START: begin
                            if (!bus.md5_busy) begin
                                start_d  = 1'b1;
                                clr_done = 1'b1;
                            end else begin
                                set_err = 1'b1;
                            end
                        end
                        OP_RD_STAT: begin
                            miso_d  = WORD_W'(status_word(err_q, done_l_q, bus.md5_busy));
                            clr_err = 1'b1;
                        end
                        OP_RD_DIG: begin
                            miso_d  = dig_word0;
                            state_d = ST_DIG;
                            cnt_d   = CNT_W'(1);
                        end
                        default: set_err = 1'b1;
                    endcase
                end

                ST_LOAD: begin
                    // A busy core must not see its message change; the word
                    // is dropped but still counted so later frames stay aligned.
                    if (bus.md5_busy) begin
                        set_err = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cnt_q;
                    end
                    if (cnt_q == CNT_W'(MSG_WORDS-1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DIG: begin
                    if (cnt_q == CNT_W'(DIG_WORDS)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        miso_d = dig_sel;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Deselect overrides whatever the same-cycle frame just did.
        if (ss_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = '0;
        end

        if (set_err) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        if (bus.md5_done) begin
            done_l_d = 1'b1;
        end else if (clr_done) begin
            done_l_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            frame_q  <= '0;
            miso_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            done_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            miso_q   <= miso_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            err_q    <= err_d;
            done_l_q <= done_l_d;
        end
    end

    assign bus.miso_word = miso_q;
    assign bus.msg_we    = we_q;
    assign bus.msg_addr  = addr_q;
    assign bus.msg_data  = frame_q;
    assign bus.md5_start = start_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_md5_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_md5_ctrl                                                 |
// | Purpose  : Directed self-checking bench for spi_md5_ctrl. Models the SPI   |
// |            shifter frame handshake and a simple MD5 core busy/done.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_md5_ctrl;
    import spi_md5_pkg::*;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    spi_md5_ctrl_if #(.WORD_W(32), .DIG_WORDS(4)) bus ();

    spi_md5_ctrl #(.WORD_W(32), .MSG_WORDS(16), .DIG_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MD5 core model: busy for 64 clk after a start pulse, then one done pulse
    logic model_busy = 1'b0;
    logic model_done = 1'b0;
    logic force_busy = 1'b0;
    int   done_count = 0;

    assign bus.md5_busy = model_busy | force_busy;
    assign bus.md5_done = model_done;

    always @(negedge clk) begin
        if (bus.md5_start === 1'b1) begin
            model_busy = 1'b1;
            repeat (64) @(negedge clk);
            model_busy = 1'b0;
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
            done_count++;
        end
    end

    // Write/start monitor
    int          we_count    = 0;
    int          start_count = 0;
    logic [3:0]  we_addr [0:63];
    logic [31:0] we_data [0:63];

    always @(negedge clk) begin
        if (bus.msg_we === 1'b1 && we_count < 64) begin
            we_addr[we_count] = bus.msg_addr;
            we_data[we_count] = bus.msg_data;
            we_count++;
        end
        if (bus.md5_start === 1'b1) start_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One SPI frame: shift_complete rises with mosi_word valid; miso_word is
    // sampled 6 clk later, i.e. within 4 clk of the synchronized frame event.
    logic [31:0] early_miso;

    task automatic send_frame(input logic [31:0] w);
        @(negedge clk);
        bus.mosi_word      = w;
        bus.shift_complete = 1'b1;
        repeat (6) @(negedge clk);
        early_miso = bus.miso_word;
        repeat (4) @(negedge clk);
        bus.shift_complete = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    int we_base;
    int st_base;
    int waited;

    initial begin
        rst                = 1'b1;
        bus.ss             = 1'b1;
        bus.shift_complete = 1'b0;
        bus.mosi_word      = 32'h0;
        bus.digest         = 128'h0123456789ABCDEF_FEDCBA9876543210;
        early_miso         = 32'h0;

        repeat (4) @(negedge clk);
        check("rst_miso",  bus.miso_word, 32'h0);
        check("rst_we",    32'(bus.msg_we), 32'h0);
        check("rst_addr",  32'(bus.msg_addr), 32'h0);
        check("rst_data",  bus.msg_data, 32'h0);
        check("rst_start", 32'(bus.md5_start), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus.ss = 1'b0;
        repeat (6) @(negedge clk);

        // Status after reset: err=0 done=0 busy=0 marker=01
        send_frame(32'h0300_0000);
        check("stat0_early", early_miso, 32'h0000_0001);
        send_frame(32'h0000_0000);
        check("nop_clears_miso", early_miso, 32'h0);

        // Full message load
        we_base = we_count;
        send_frame(32'h0100_0000);
        for (int i = 0; i < 16; i++) send_frame(32'hA000_0000 + 32'(i));
        check("load_we_count", 32'(we_count - we_base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("load_addr%0d", i), 32'(we_addr[we_base+i]), 32'(i));
            check($sformatf("load_data%0d", i), we_data[we_base+i], 32'hA000_0000 + 32'(i));
        end
        check("load_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // START, core runs, completes
        st_base = start_count;
        send_frame(32'h0200_0000);
        check("start_pulse_count", 32'(start_count - st_base), 32'd1);
        waited = 0;
        while (done_count == 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", 32'(done_count), 32'd1);
        repeat (2) @(negedge clk);
        // err=0 done=1 busy=0 marker=01
        send_frame(32'h0300_0000);
        check("stat_after_done", early_miso, 32'h0000_0009);

        // Digest readout
        send_frame(32'h0400_0000);
        check("dig_w0", early_miso, 32'h0123_4567);
        send_frame(32'h0000_0000);
        check("dig_w1", early_miso, 32'h89AB_CDEF);
        send_frame(32'h0000_0000);
        check("dig_w2", early_miso, 32'hFEDC_BA98);
        send_frame(32'h0000_0000);
        check("dig_w3", early_miso, 32'h7654_3210);
        send_frame(32'h0300_0000);
        check("dig_end_zero", early_miso, 32'h0);
        check("dig_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Aborted load: 5 words then deselect
        we_base = we_count;
        send_frame(32'h0100_0000);
        for (int i = 0; i < 5; i++) send_frame(32'hB000_0000 + 32'(i));
        @(negedge clk);
        bus.ss = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("abort_cnt_zero", 32'(dut.cnt_q), 32'h0);
        check("abort_we_count", 32'(we_count - we_base), 32'd5);
        bus.ss = 1'b0;
        repeat (6) @(negedge clk);
        send_frame(32'h0300_0000);
        check("abort_next_is_cmd", early_miso, 32'h0000_0009);
        check("abort_no_extra_we", 32'(we_count - we_base), 32'd5);

        // Error paths: bad opcode, START while busy
        st_base = start_count;
        send_frame(32'h7F00_0000);
        force_busy = 1'b1;
        send_frame(32'h0200_0000);
        force_busy = 1'b0;
        check("busy_start_no_pulse", 32'(start_count - st_base), 32'd0);
        send_frame(32'h0300_0000);
        check("stat_err_set", early_miso, 32'h0000_0019);
        send_frame(32'h0300_0000);
        check("stat_err_cleared", early_miso, 32'h0000_0009);
        send_frame(32'h0000_0000);
        check("final_nop_zero", early_miso, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
